ssl_tx: RTL and testbench
=========================

# ssl_tx

Parallel-to-serial nibble transmitter: the transmit-side counterpart of the 4-bit serial shift loader. It accepts one NDATA-bit word and emits it as NDATA/4 nibbles, LSB nibble first, each tagged with its bit offset, over a valid/ready handshake. It sits between the word-level data source and the 4-bit link that feeds the loader's `din`/`cntin` inputs.

## Interface
- NDATA, 128, word width in bits; must be a multiple of 4 and at least 8.
- NDATA_LOG, $clog2(NDATA), localparam; width of the offset counter.
- NNIB, NDATA/4, localparam; nibbles per word.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  global enable; when low, all state and outputs hold.
- load  in  1  request to load `din`.
- din  in  NDATA  word to transmit; sampled only when a load is accepted.
- busy  out  1  a word is held and not yet fully transferred.
- dout  out  4  current nibble.
- cntout  out  NDATA_LOG  bit offset of `dout[0]` within the word (0, 4, 8, … NDATA-4).
- dout_valid  out  1  `dout`/`cntout` are valid.
- dout_ready  in  1  downstream accepts the nibble this cycle.
- last  out  1  high with `dout_valid` on the final nibble (cntout = NDATA-4).
- done  out  1  one-cycle pulse the cycle after the final nibble transfers.
- drop  out  1  one-cycle pulse when a load is refused.

## Operation
- States: IDLE and SEND.
- Registers: a shift register `sh[NDATA-1:0]` and a nibble counter `idx[NDATA_LOG-3:0]`.
- Derived outputs:
  - `dout = sh[3:0]`
  - `cntout = {idx, 2'b00}`
  - `dout_valid = busy = (state == SEND)`
  - `last = (state == SEND) && (idx == NNIB-1)`
- Load acceptance (`acc`): `ena && load && (state == IDLE || xfer_last)`.
  - On `acc`: `sh <= din`, `idx <= 0`, state becomes SEND.
- Transfer (`xfer`): `ena && dout_valid && dout_ready`.
  - On `xfer` without `last`: `sh <= {4'b0, sh[NDATA-1:4]}`, `idx <= idx + 1`.
- Final transfer (`xfer_last`): `xfer && last`.
  - `done` pulses on the next cycle.
  - The next state is IDLE unless `acc` occurs in the same cycle, in which case the state stays SEND with the new word. This gives back-to-back words with no bubble.
- Refused load: `ena && load && state == SEND && !xfer_last`.
  - `drop` pulses on the next cycle; the held word is unaffected.
- `idx` never wraps past NNIB-1; leaving SEND resets it to 0.
- `ena` low:
  - No accept, no transfer, no drop.
  - `done` and `drop` deassert.
  - All other outputs hold their values.

## Timing
- Reset (`rst` high at an edge) wins over everything, including `ena` low. State after reset:
  - state IDLE, `sh` = 0, `idx` = 0
  - `busy`, `dout_valid`, `last`, `done`, `drop` = 0
  - `dout` = 0, `cntout` = 0
- Load latency: `load` sampled at edge N makes `dout_valid` = 1 with `dout = din[3:0]` and `cntout` = 0 after edge N.
- Throughput: one nibble per cycle while `dout_ready` = 1 and `ena` = 1. A full word takes NNIB cycles from first valid to `done`.
- Backpressure: with `dout_ready` low, `dout`, `cntout` and `last` stay stable; `dout_valid` never drops mid-word.
- Reset mid-word: the word is abandoned, there is no `done`, and outputs return to reset values on the next cycle.
- `done` and `drop` are registered outputs, each exactly one cycle wide.

## Test plan
- Reset then single word, NDATA=128, `din` = 128'h0123456789ABCDEF_FEDCBA9876543210, `dout_ready` = 1 → 32 valid cycles.
  - `dout` sequence 0,1,2,…,F,F,E,…,0; `cntout` 0,4,…,124.
  - `last` high only at `cntout` = 124; `done` pulses the cycle after; `busy` low afterwards.
- Backpressure: `dout_ready` toggled 1,0,0,1,… throughout the word → identical nibble sequence; `dout`/`cntout` hold while ready is low; 32 transfers total.
- Back-to-back: second `load` asserted in the same cycle as the first word's last transfer → no idle cycle; the next cycle shows the new word's nibble 0 with `cntout` = 0.
- Refused load: `load` asserted with `cntout` = 40 → `drop` pulses once; the remaining nibbles still come from the original word.
- Enable gating: `ena` low for 5 cycles at `cntout` = 64 → no state change and no `done`/`drop`; transfer resumes at 64.
- Reset mid-word at `cntout` = 20 → next cycle `busy` = 0, `dout` = 0, `cntout` = 0; no `done` pulse.

Source files
------------

// File: rtl/ssl_tx.sv
//==============================================================================
// Module      : ssl_tx
// Description : Parallel-to-serial nibble transmitter, LSB nibble first, with
//               bit-offset tag and valid/ready handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ssl_tx #(
    parameter int NDATA = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     load,
    input  logic [NDATA-1:0]         din,
    output logic                     busy,
    output logic [3:0]               dout,
    output logic [$clog2(NDATA)-1:0] cntout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     last,
    output logic                     done,
    output logic                     drop
);

    localparam int NDATA_LOG = $clog2(NDATA);
    localparam int NNIB      = NDATA / 4;
    localparam int IW        = NDATA_LOG - 2;
    localparam logic [IW-1:0] c_IDX_LAST = IW'(NNIB - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NDATA-1:0] r_sh;
    logic [NDATA-1:0] w_sh_nxt;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic             r_done;
    logic             r_drop;

    logic w_send;
    logic w_last;
    logic w_xfer;
    logic w_xfer_last;
    logic w_acc;
    logic w_refuse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_xfer_last;
            r_drop  <= w_refuse;
        end else begin
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end
    end

    // A load that coincides with the final transfer is accepted so words
    // can stream back to back without an idle cycle.
    always_comb begin
        w_send      = (r_state == S_SEND);
        w_last      = w_send && (r_idx == c_IDX_LAST);
        w_xfer      = ena && w_send && dout_ready;
        w_xfer_last = w_xfer && w_last;
        w_acc       = ena && load && (!w_send || w_xfer_last);
        w_refuse    = ena && load && w_send && !w_xfer_last;

        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_idx_nxt   = r_idx;

        if (w_acc) begin
            w_state_nxt = S_SEND;
            w_sh_nxt    = din;
            w_idx_nxt   = '0;
        end else if (w_xfer_last) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end else if (w_xfer) begin
            w_sh_nxt    = {4'b0000, r_sh[NDATA-1:4]};
            w_idx_nxt   = r_idx + IW'(1);
        end
    end

    assign busy       = (r_state == S_SEND);
    assign dout_valid = (r_state == S_SEND);
    assign dout       = r_sh[3:0];
    assign cntout     = {r_idx, 2'b00};
    assign last       = (r_state == S_SEND) && (r_idx == c_IDX_LAST);
    assign done       = r_done;
    assign drop       = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_ssl_tx.sv
//==============================================================================
// Module      : tb_ssl_tx
// Description : Self-checking bench for ssl_tx against a word/position model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ssl_tx;

    localparam int NDATA     = 128;
    localparam int NDATA_LOG = $clog2(NDATA);
    localparam int NNIB      = NDATA / 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 ena = 1'b1;
    logic                 load = 1'b0;
    logic [NDATA-1:0]     din = '0;
    logic                 busy;
    logic [3:0]           dout;
    logic [NDATA_LOG-1:0] cntout;
    logic                 dout_valid;
    logic                 dout_ready = 1'b1;
    logic                 last;
    logic                 done;
    logic                 drop;

    int checks   = 0;
    int failures = 0;

    // Reference model: the accepted word, which nibble is on the wire, flags.
    logic [NDATA-1:0] m_word  = '0;
    int               m_pos   = 0;
    logic             m_busy  = 1'b0;
    logic             m_done  = 1'b0;
    logic             m_drop  = 1'b0;
    logic             m_clean = 1'b1;

    ssl_tx #(.NDATA(NDATA)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .load       (load),
        .din        (din),
        .busy       (busy),
        .dout       (dout),
        .cntout     (cntout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .last       (last),
        .done       (done),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [NDATA-1:0] w, input int p);
        logic [NDATA-1:0] t;
        t = w >> (4 * p);
        return t[3:0];
    endfunction

    task automatic check_outputs();
        chk("busy", 32'(busy), 32'(m_busy));
        chk("dout_valid", 32'(dout_valid), 32'(m_busy));
        chk("last", 32'(last), 32'(m_busy && (m_pos == NNIB - 1)));
        chk("done", 32'(done), 32'(m_done));
        chk("drop", 32'(drop), 32'(m_drop));
        chk("cntout", 32'(cntout), m_busy ? 32'(4 * m_pos) : 32'd0);
        if (m_busy || m_clean)
            chk("dout", 32'(dout), m_busy ? 32'(nib(m_word, m_pos)) : 32'd0);
    endtask

    // One clock: advance the model from the inputs presented, then compare.
    task automatic cyc();
        logic lastnow, xfer, xl, acc;
        if (rst) begin
            m_busy = 1'b0; m_pos = 0; m_word = '0;
            m_done = 1'b0; m_drop = 1'b0; m_clean = 1'b1;
        end else if (!ena) begin
            m_done = 1'b0; m_drop = 1'b0;
        end else begin
            lastnow = m_busy && (m_pos == NNIB - 1);
            xfer    = m_busy && dout_ready;
            xl      = xfer && lastnow;
            acc     = load && (!m_busy || xl);
            m_done  = xl;
            m_drop  = load && m_busy && !xl;
            if (acc) begin
                m_word = din; m_pos = 0; m_busy = 1'b1; m_clean = 1'b0;
            end else if (xl) begin
                m_busy = 1'b0; m_pos = 0;
            end else if (xfer) begin
                m_pos++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run_to_pos(input int p);
        int  n;
        logic reached;
        n = 0;
        while (!(m_busy && m_pos == p) && n < 200) begin
            cyc();
            n++;
        end
        reached = m_busy && (m_pos == p);
        chk("reach_pos", 32'(reached), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 300) begin
            cyc();
            n++;
        end
        chk("drain", 32'(m_busy), 32'd0);
        cyc();
    endtask

    task automatic start_word(input logic [NDATA-1:0] w);
        din  = w;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    function automatic logic [NDATA-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [NDATA-1:0] wa, wb;
        int xfers, n, p;
        logic seen_done;

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Single word at full rate: dout follows 0..F,F..0, 32 valid cycles
        wa = 128'h0123456789ABCDEF_FEDCBA9876543210;
        dout_ready = 1'b1;
        start_word(wa);
        for (int i = 0; i < NNIB; i++) begin
            chk("seq_dout", 32'(dout), (i < 16) ? i : 31 - i);
            chk("seq_cnt", 32'(cntout), 32'(4 * i));
            chk("seq_last", 32'(last), 32'(i == NNIB - 1));
            cyc();
        end
        chk("seq_done", 32'(done), 32'd1);
        chk("seq_busy_after", 32'(busy), 32'd0);
        cyc();
        chk("done_one_cycle", 32'(done), 32'd0);

        // Backpressure 1,0,0 pattern: 32 transfers, values hold while stalled
        start_word(wa);
        xfers = 0;
        n = 0;
        while (m_busy && n < 200) begin
            dout_ready = (n % 3 == 0);
            if (busy && dout_ready) xfers++;
            cyc();
            n++;
        end
        dout_ready = 1'b1;
        chk("bp_xfers", 32'(xfers), 32'(NNIB));
        chk("bp_done", 32'(done), 32'd1);
        cyc();

        // Back-to-back: load coincides with final transfer of previous word
        wa = rnd_word();
        wb = rnd_word();
        start_word(wa);
        run_to_pos(NNIB - 1);
        din  = wb;
        load = 1'b1;
        cyc();
        load = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_cnt", 32'(cntout), 32'd0);
        chk("b2b_dout", 32'(dout), 32'(wb[3:0]));
        chk("b2b_done", 32'(done), 32'd1);
        drain();

        // Refused load at offset 40
        wa = rnd_word();
        start_word(wa);
        run_to_pos(10);
        din  = rnd_word();
        load = 1'b1;
        cyc();
        load = 1'b0;
        chk("refuse_drop", 32'(drop), 32'd1);
        chk("refuse_cnt", 32'(cntout), 32'd44);
        chk("refuse_dout", 32'(dout), 32'(nib(wa, 11)));
        cyc();
        chk("refuse_drop_one", 32'(drop), 32'd0);
        drain();

        // Enable gating at offset 64
        wa = rnd_word();
        start_word(wa);
        run_to_pos(16);
        ena  = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("ena_hold_cnt", 32'(cntout), 32'd64);
            chk("ena_hold_drop", 32'(drop), 32'd0);
        end
        load = 1'b0;
        ena  = 1'b1;
        cyc();
        chk("ena_resume", 32'(cntout), 32'd68);
        drain();

        // Reset mid-word at offset 20: no done afterwards
        wa = rnd_word();
        start_word(wa);
        run_to_pos(5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_cnt", 32'(cntout), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < NNIB + 2; i++) begin
            cyc();
            if (done) seen_done = 1'b1;
        end
        chk("rst_no_done", 32'(seen_done), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            p          = $urandom_range(0, 99);
            load       = ($urandom_range(0, 15) == 0);
            din        = rnd_word();
            dout_ready = ($urandom_range(0, 3) != 0);
            ena        = ($urandom_range(0, 9) != 0);
            rst        = (p == 0) && ($urandom_range(0, 3) == 0);
            cyc();
        end
        rst = 1'b0; ena = 1'b1; load = 1'b0; dout_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
